icache_miss_responder: RTL and testbench

Memory-side responder for instruction-cache line-fill misses. It accepts a miss request from the instruction cache inside the fetch stage, waits a programmable fixed latency, then returns one full cache line from an internal line-organised backing store. A side load port fills the store with the program image before and during simulation. The block sits between the core's instruction cache and the top-level memory model.

---
 rtl/icache_miss_responder.sv | 120 ++++++++++++
 tb/tb_icache_miss_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_miss_responder.sv
// Line-fill responder for icache misses: waits LATENCY cycles after accepting a
// request, then returns one full line from a loadable line-organised store.
//   state  | meaning
//   S_IDLE | no request in flight
//   S_WAIT | request accepted, latency counter running
//   S_RESP | response line presented for one cycle

`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

module icache_miss_responder #(
  parameter int MEM_LINES  = 256,
  parameter int LATENCY    = 10,
  parameter int LINE_WIDTH = `ICACHE_LINE_WIDTH,
  parameter int REQ_WIDTH  = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid_miss,
  input  logic [REQ_WIDTH-1:0]         req_info_miss,
  output logic                         rsp_valid_miss,
  output logic [LINE_WIDTH-1:0]        rsp_data_miss,
  input  logic                         load_valid,
  input  logic [$clog2(MEM_LINES)-1:0] load_index,
  input  logic [LINE_WIDTH-1:0]        load_data,
  output logic                         busy,
  output logic                         req_overflow
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_rsp_valid;
  logic [LINE_WIDTH-1:0] r_rsp_data;
  logic                  r_busy;
  logic                  r_overflow;
  logic [LINE_WIDTH-1:0] r_mem [MEM_LINES];

  logic [IDX_W-1:0]      w_idx;
  logic [LINE_WIDTH-1:0] w_rd_data;
  logic                  w_unused;

  // addr sits in the low bits of the request descriptor; high address bits wrap
  assign w_idx    = req_info_miss[OFF_W +: IDX_W];
  assign w_unused = ^{req_info_miss[REQ_WIDTH-1:OFF_W+IDX_W], req_info_miss[OFF_W-1:0]};

  // a load landing on the same edge that enters RESP must be visible in the response
  assign w_rd_data = (load_valid && (load_index == r_idx)) ? load_data : r_mem[r_idx];

  always_ff @(posedge clock) begin
    if (load_valid) begin
      r_mem[load_index] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_miss) begin
            r_idx   <= w_idx;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (req_valid_miss) begin
            r_overflow <= 1'b1;
          end
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_data  <= '0;
          // the edge leaving RESP may already accept the next miss
          if (req_valid_miss) begin
            r_idx   <= w_idx;
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_miss = r_rsp_valid;
  assign rsp_data_miss  = r_rsp_data;
  assign busy           = r_busy;
  assign req_overflow   = r_overflow;

endmodule

// File: tb/tb_icache_miss_responder.sv
// Scoreboard bench for icache_miss_responder: two instances (LATENCY 4 and 1)
// share clock, reset and the load port and are checked against a line-store model.

module tb_icache_miss_responder;

  logic         clock;
  logic         reset;
  logic         req_v [2];
  logic [63:0]  req_i [2];
  logic         rsp_v [2];
  logic [127:0] rsp_d [2];
  logic         busy_o [2];
  logic         ovf_o [2];
  logic         load_valid;
  logic [7:0]   load_index;
  logic [127:0] load_data;

  icache_miss_responder #(.MEM_LINES(256), .LATENCY(4), .LINE_WIDTH(128), .REQ_WIDTH(64)) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid_miss(req_v[0]), .req_info_miss(req_i[0]),
    .rsp_valid_miss(rsp_v[0]), .rsp_data_miss(rsp_d[0]),
    .load_valid(load_valid), .load_index(load_index), .load_data(load_data),
    .busy(busy_o[0]), .req_overflow(ovf_o[0])
  );

  icache_miss_responder #(.MEM_LINES(256), .LATENCY(1), .LINE_WIDTH(128), .REQ_WIDTH(64)) u_dut1 (
    .clock(clock), .reset(reset),
    .req_valid_miss(req_v[1]), .req_info_miss(req_i[1]),
    .rsp_valid_miss(rsp_v[1]), .rsp_data_miss(rsp_d[1]),
    .load_valid(load_valid), .load_index(load_index), .load_data(load_data),
    .busy(busy_o[1]), .req_overflow(ovf_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: line store, accepted requests and their due cycles
  typedef struct {int inst; int due; int idx;} exp_t;
  exp_t         sbq[$];
  logic [127:0] mmem [256];
  int           lat [2] = '{4, 1};
  bit           have [2];
  int           acc_k [2];
  bit           ovf_exp [2];
  int           cyc = 0;
  bit           mon_on = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  function automatic int line_idx(logic [63:0] info);
    return int'(info[31:0] / 16) % 256;
  endfunction

  task automatic chk(string name, bit ok, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (req_v[i]) begin
          if (have[i] && cyc <= acc_k[i] + lat[i]) begin
            ovf_exp[i] = 1'b1;
          end else begin
            have[i]  = 1'b1;
            acc_k[i] = cyc;
            sbq.push_back('{i, cyc + lat[i], line_idx(req_i[i])});
          end
        end
      end
    end
    if (load_valid) mmem[load_index] = load_data;
  end

  always @(negedge clock) begin
    #2;
    if (mon_on) begin
      for (int i = 0; i < 2; i++) begin
        int           h;
        bit           erv;
        bit           eb;
        logic [127:0] ed;
        h = -1;
        for (int j = 0; j < sbq.size(); j++) begin
          if (h < 0 && sbq[j].inst == i) h = j;
        end
        if (h >= 0 && sbq[h].due < cyc) begin
          chk($sformatf("rsp_missing[%0d]", i), 1'b0, 128'd0, 128'd1);
          sbq.delete(h);
          h = -1;
        end
        erv = 1'b0;
        ed  = '0;
        if (h >= 0) begin
          if (sbq[h].due == cyc) begin
            erv = 1'b1;
            ed  = mmem[sbq[h].idx];
          end
        end
        chk($sformatf("rsp_valid[%0d]", i), rsp_v[i] === erv, 128'(rsp_v[i]), 128'(erv));
        chk($sformatf("rsp_data[%0d]", i), rsp_d[i] === ed, rsp_d[i], ed);
        if (erv) sbq.delete(h);
        eb = have[i] && cyc >= acc_k[i] && cyc <= acc_k[i] + lat[i];
        chk($sformatf("busy[%0d]", i), busy_o[i] === eb, 128'(busy_o[i]), 128'(eb));
        chk($sformatf("overflow[%0d]", i), ovf_o[i] === ovf_exp[i], 128'(ovf_o[i]), 128'(ovf_exp[i]));
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clock);
      req_v[0]   = 1'b0;
      req_v[1]   = 1'b0;
      load_valid = 1'b0;
    end
  endtask

  task automatic set_req(int i, logic [31:0] addr);
    req_v[i] = 1'b1;
    req_i[i] = {$urandom, addr};
  endtask

  task automatic set_load(int idx, logic [127:0] d);
    load_valid = 1'b1;
    load_index = 8'(idx);
    load_data  = d;
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[11:4] = 8'($urandom_range(0, 7));
    return a;
  endfunction

  task automatic do_reset(int hold);
    req_v[0]   = 1'b0;
    req_v[1]   = 1'b0;
    load_valid = 1'b0;
    reset      = 1'b0;
    sbq.delete();
    for (int i = 0; i < 2; i++) begin
      have[i]    = 1'b0;
      ovf_exp[i] = 1'b0;
    end
    mon_on = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_rsp_valid[%0d]", i), rsp_v[i] === 1'b0, 128'(rsp_v[i]), 128'd0);
      chk($sformatf("rst_rsp_data[%0d]", i), rsp_d[i] === 128'd0, rsp_d[i], 128'd0);
      chk($sformatf("rst_busy[%0d]", i), busy_o[i] === 1'b0, 128'(busy_o[i]), 128'd0);
      chk($sformatf("rst_overflow[%0d]", i), ovf_o[i] === 1'b0, 128'(ovf_o[i]), 128'd0);
    end
    idle(hold);
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    req_v[0]   = 1'b0;
    req_v[1]   = 1'b0;
    req_i[0]   = '0;
    req_i[1]   = '0;
    load_valid = 1'b0;
    load_index = '0;
    load_data  = '0;
    idle(1);
    do_reset(2);

    for (int i = 0; i < 256; i++) begin
      set_load(i, rnd_line());
      idle(1);
    end

    // basic fill, then wrap-around address with byte offset
    set_load(3, 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003);
    idle(1);
    set_req(0, 32'h0000_0030);
    idle(8);
    set_req(0, 32'h0000_1034);
    set_req(1, 32'h0000_5034);
    idle(8);

    // load to the in-flight index during WAIT
    set_load(5, rnd_line());
    idle(1);
    set_req(0, 32'h0000_0058);
    idle(2);
    set_load(5, 128'h1);
    idle(8);

    // load in the RESP cycle plus a request accepted on the edge leaving RESP
    set_req(0, 32'h0000_0050);
    idle(5);
    set_load(5, rnd_line());
    set_req(0, 32'h0000_005C);
    idle(10);
    set_req(1, 32'h0000_0050);
    idle(2);
    set_load(5, rnd_line());
    set_req(1, 32'h0000_0050);
    idle(6);

    // back-to-back at the maximum rate for each latency
    for (int r = 0; r < 4; r++) begin
      set_req(1, rnd_addr());
      idle(2);
    end
    for (int r = 0; r < 3; r++) begin
      set_req(0, rnd_addr());
      idle(5);
    end
    idle(4);

    // overflow: second pulse two cycles into the first request
    set_req(0, 32'h0000_0040);
    idle(2);
    set_req(0, 32'h0000_0080);
    idle(10);

    // reset two cycles into WAIT
    set_req(0, 32'h0000_0030);
    set_req(1, 32'h0000_0030);
    idle(3);
    do_reset(2);
    idle(10);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        if ($urandom_range(0, 5) == 0) set_req(0, rnd_addr());
        if ($urandom_range(0, 2) == 0) set_req(1, rnd_addr());
        if ($urandom_range(0, 2) == 0) begin
          set_load(($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255), rnd_line());
        end
        idle(1);
      end
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
